// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } pipe_state_e;

   localparam int REG_AW_DEFAULT = 5;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_OFF      = 7'b0000000;
   localparam ctrl_t CTRL_RUN      = 7'b1101010;
   localparam ctrl_t CTRL_LOAD_USE = 7'b0001110;
   localparam ctrl_t CTRL_REDIRECT = 7'b1111110;
   localparam ctrl_t CTRL_FREEZE   = 7'b0000001;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the ID instruction.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   input  logic              rs1_used_i,
   input  logic              rs2_used_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              ex_load_i,
   output logic              load_use_o
);

   logic rs1Match;
   logic rs2Match;

   // x0 never carries a real dependency, so a load targeting it never stalls
   assign rs1Match   = rs1_used_i && (rs1_addr_i == ex_rd_addr_i);
   assign rs2Match   = rs2_used_i && (rs2_addr_i == ex_rd_addr_i);
   assign load_use_o = ex_load_i && (ex_rd_addr_i != '0) && (rs1Match || rs2Match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: load-use stalls, EX redirects, data-memory freeze with timeout,
// plus stall and flush event counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_AW      = REG_AW_DEFAULT,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [REG_AW-1:0]     id_rs1_addr_i,
   input  logic [REG_AW-1:0]     id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic [REG_AW-1:0]     ex_rd_addr_i,
   input  logic                  ex_load_i,
   input  logic                  ex_redirect_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ready_i,
   output logic                  pc_en_o,
   output logic                  if_id_en_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_en_o,
   output logic                  id_ex_flush_o,
   output logic                  ex_mem_en_o,
   output logic                  mem_wb_flush_o,
   output logic                  halt_o,
   output logic [DATA_WIDTH-1:0] stall_cnt_o,
   output logic [DATA_WIDTH-1:0] flush_cnt_o
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   pipe_state_e           state_q;
   logic [WCW-1:0]        wait_cnt_q;
   logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                  loadUse;
   logic                  frozen;
   ctrl_t                 ctrl;

   hazard_detect #(
      .REG_AW(REG_AW)
   ) u_hazard_detect (
      .rs1_addr_i  (id_rs1_addr_i),
      .rs2_addr_i  (id_rs2_addr_i),
      .rs1_used_i  (id_rs1_used_i),
      .rs2_used_i  (id_rs2_used_i),
      .ex_rd_addr_i(ex_rd_addr_i),
      .ex_load_i   (ex_load_i),
      .load_use_o  (loadUse)
   );

   // Once waiting, the outstanding access keeps the pipe frozen until the memory answers
   assign frozen = (state_q == WAIT) ? !mem_ready_i
                                     : ((state_q == RUN) && mem_req_i && !mem_ready_i);

   always_comb begin
      ctrl = CTRL_OFF;
      if (!rst_ni || (state_q == HALT)) begin
         ctrl = CTRL_OFF;
      end else if (frozen) begin
         ctrl = CTRL_FREEZE;
      end else if (ex_redirect_i) begin
         ctrl = CTRL_REDIRECT;
      end else if (loadUse) begin
         ctrl = CTRL_LOAD_USE;
      end else begin
         ctrl = CTRL_RUN;
      end
   end

   assign pc_en_o        = ctrl.pc_en;
   assign if_id_en_o     = ctrl.if_id_en;
   assign if_id_flush_o  = ctrl.if_id_flush;
   assign id_ex_en_o     = ctrl.id_ex_en;
   assign id_ex_flush_o  = ctrl.id_ex_flush;
   assign ex_mem_en_o    = ctrl.ex_mem_en;
   assign mem_wb_flush_o = ctrl.mem_wb_flush;
   assign halt_o         = (state_q == HALT);

   // wait_cnt_q holds the number of consecutive frozen cycles seen so far
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (frozen) begin
                  if (MEM_TIMEOUT <= 1) begin
                     state_q <= HALT;
                  end else begin
                     state_q    <= WAIT;
                     wait_cnt_q <= WCW'(1);
                  end
               end
            end
            WAIT: begin
               if (mem_ready_i) begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q >= WCW'(MEM_TIMEOUT - 1)) begin
                  state_q <= HALT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q    <= RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctrl.pc_en) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (ctrl.if_id_flush) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, multi-cycle corner sequences and a randomized
// run compared against a rule-level reference model.
module tb_pipeline_ctrl;

   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rstN;
   logic [AW-1:0] rs1Addr, rs2Addr, rdAddr;
   logic          rs1Used, rs2Used, exLoad, exRedirect, memReq, memReady;
   logic          pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbFlush, halt;
   logic [DW-1:0] stallCnt, flushCnt;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       load;
      logic       redirect;
      logic       req;
      logic       ready;
   } stim_t;

   typedef struct packed {
      logic pcEn;
      logic ifIdEn;
      logic ifIdFlush;
      logic idExEn;
      logic idExFlush;
      logic exMemEn;
      logic memWbFlush;
      logic halt;
   } ctrl_t;

   typedef struct packed {
      stim_t s;
      ctrl_t c;
   } vec_t;

   localparam ctrl_t C_OFF  = 8'b00000000;
   localparam ctrl_t C_RUN  = 8'b11010100;
   localparam ctrl_t C_LU   = 8'b00011100;
   localparam ctrl_t C_RD   = 8'b11111100;
   localparam ctrl_t C_FRZ  = 8'b00000010;
   localparam ctrl_t C_HALT = 8'b00000001;

   int            checks = 0;
   int            errors = 0;
   int            modelWaitRun;
   bit            modelHalted;
   logic [DW-1:0] modelStall;
   logic [DW-1:0] modelFlush;
   ctrl_t         dutCtrl;
   ctrl_t         lastDut;
   vec_t          vecs [14];

   assign dutCtrl = {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbFlush, halt};

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .DATA_WIDTH (DW),
      .REG_AW     (AW),
      .MEM_TIMEOUT(TMO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .id_rs1_addr_i (rs1Addr),
      .id_rs2_addr_i (rs2Addr),
      .id_rs1_used_i (rs1Used),
      .id_rs2_used_i (rs2Used),
      .ex_rd_addr_i  (rdAddr),
      .ex_load_i     (exLoad),
      .ex_redirect_i (exRedirect),
      .mem_req_i     (memReq),
      .mem_ready_i   (memReady),
      .pc_en_o       (pcEn),
      .if_id_en_o    (ifIdEn),
      .if_id_flush_o (ifIdFlush),
      .id_ex_en_o    (idExEn),
      .id_ex_flush_o (idExFlush),
      .ex_mem_en_o   (exMemEn),
      .mem_wb_flush_o(memWbFlush),
      .halt_o        (halt),
      .stall_cnt_o   (stallCnt),
      .flush_cnt_o   (flushCnt)
   );

   function automatic stim_t mk(int rs1, int rs2, int u1, int u2, int rd,
                                int ld, int rdr, int rq, int rdy);
      stim_t s;
      s.rs1      = 5'(rs1);
      s.rs2      = 5'(rs2);
      s.u1       = 1'(u1);
      s.u2       = 1'(u2);
      s.rd       = 5'(rd);
      s.load     = 1'(ld);
      s.redirect = 1'(rdr);
      s.req      = 1'(rq);
      s.ready    = 1'(rdy);
      return s;
   endfunction

   // Expected control word from the priority rules: reset/halt, freeze, redirect, load-use, run
   function automatic ctrl_t expectCtrl(stim_t s);
      ctrl_t c;
      bit    memStuck;
      bit    hazard;
      c        = C_OFF;
      memStuck = (modelWaitRun > 0) ? !s.ready : (s.req && !s.ready);
      hazard   = s.load && (s.rd != 5'd0) &&
                 ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
      if (!rstN)            c = C_OFF;
      else if (modelHalted) c = C_HALT;
      else if (memStuck)    c = C_FRZ;
      else if (s.redirect)  c = C_RD;
      else if (hazard)      c = C_LU;
      else                  c = C_RUN;
      return c;
   endfunction

   task automatic clearModel();
      modelWaitRun = 0;
      modelHalted  = 1'b0;
      modelStall   = '0;
      modelFlush   = '0;
   endtask

   task automatic updateModel(ctrl_t c);
      if (!rstN) begin
         clearModel();
      end else begin
         if (!c.pcEn)     modelStall = modelStall + 1'b1;
         if (c.ifIdFlush) modelFlush = modelFlush + 1'b1;
         if (!modelHalted) begin
            if (c.memWbFlush) begin
               modelWaitRun++;
               if (modelWaitRun >= TMO) modelHalted = 1'b1;
            end else begin
               modelWaitRun = 0;
            end
         end
      end
   endtask

   task automatic checkValue(string what, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", what, actual, expected, $time);
      end
   endtask

   task automatic checkOutput(ctrl_t expCtrl);
      checkValue("ctrl", 32'(dutCtrl), 32'(expCtrl));
      checkValue("stall_cnt", 32'(stallCnt), 32'(modelStall));
      checkValue("flush_cnt", 32'(flushCnt), 32'(modelFlush));
   endtask

   // Drive one cycle of inputs, compare at the falling edge, advance the model on the rising edge
   task automatic applyStimulus(stim_t s, logic rstVal);
      ctrl_t expCtrl;
      rstN       = rstVal;
      rs1Addr    = s.rs1;
      rs2Addr    = s.rs2;
      rs1Used    = s.u1;
      rs2Used    = s.u2;
      rdAddr     = s.rd;
      exLoad     = s.load;
      exRedirect = s.redirect;
      memReq     = s.req;
      memReady   = s.ready;
      if (!rstVal) clearModel();
      @(negedge clk);
      expCtrl = expectCtrl(s);
      lastDut = dutCtrl;
      checkOutput(expCtrl);
      @(posedge clk);
      updateModel(expCtrl);
      #1;
   endtask

   stim_t idle, frz, rdyOnly;

   initial begin
      rstN = 1'b0;
      clearModel();
      idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      frz     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      rdyOnly = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);

      vecs[0]  = {mk(0, 0, 0, 0, 0, 0, 0, 0, 0), C_RUN};
      vecs[1]  = {mk(1, 5, 1, 1, 5, 1, 0, 0, 0), C_LU};
      vecs[2]  = {mk(1, 5, 1, 1, 5, 0, 0, 0, 0), C_RUN};
      vecs[3]  = {mk(0, 0, 1, 1, 0, 1, 0, 0, 0), C_RUN};
      vecs[4]  = {mk(3, 5, 1, 0, 5, 1, 0, 0, 0), C_RUN};
      vecs[5]  = {mk(7, 2, 1, 1, 7, 1, 0, 0, 0), C_LU};
      vecs[6]  = {mk(7, 2, 1, 1, 7, 0, 0, 0, 0), C_RUN};
      vecs[7]  = {mk(1, 5, 1, 1, 5, 1, 1, 0, 0), C_RD};
      vecs[8]  = {mk(0, 0, 0, 0, 0, 0, 0, 0, 1), C_RUN};
      vecs[9]  = {mk(0, 0, 0, 0, 0, 0, 0, 1, 1), C_RUN};
      vecs[10] = {mk(0, 0, 0, 0, 0, 0, 1, 1, 0), C_FRZ};
      vecs[11] = {mk(0, 0, 0, 0, 0, 0, 1, 1, 1), C_RD};
      vecs[12] = {mk(1, 5, 1, 1, 5, 1, 0, 1, 0), C_FRZ};
      vecs[13] = {mk(1, 5, 1, 1, 5, 1, 0, 1, 1), C_LU};

      applyStimulus(idle, 1'b0);
      checkValue("reset_ctrl", 32'(lastDut), 32'(C_OFF));
      applyStimulus(idle, 1'b0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].s, 1'b1);
         checkValue($sformatf("vec%0d", i), 32'(lastDut), 32'(vecs[i].c));
      end

      // Redirect together with load-use: redirect wins, one flush event
      applyStimulus(idle, 1'b0);
      applyStimulus(mk(1, 5, 1, 1, 5, 1, 1, 0, 0), 1'b1);
      checkValue("redir_ctrl", 32'(lastDut), 32'(C_RD));
      checkValue("redir_flush_cnt", 32'(flushCnt), 32'd1);

      // Three-cycle memory wait
      applyStimulus(idle, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(frz, 1'b1);
         checkValue("wait_ctrl", 32'(lastDut), 32'(C_FRZ));
      end
      checkValue("wait_stall_cnt", 32'(stallCnt), 32'd3);
      applyStimulus(rdyOnly, 1'b1);
      checkValue("wait_release", 32'(lastDut), 32'(C_RUN));

      // Reset in the middle of a wait
      applyStimulus(idle, 1'b0);
      applyStimulus(frz, 1'b1);
      applyStimulus(frz, 1'b1);
      applyStimulus(frz, 1'b0);
      checkValue("rst_wait_ctrl", 32'(lastDut), 32'(C_OFF));
      applyStimulus(idle, 1'b1);
      checkValue("rst_wait_run", 32'(lastDut), 32'(C_RUN));
      checkValue("rst_wait_stall", 32'(stallCnt), 32'd0);

      // Timeout into sticky halt, then reset out of it
      for (int i = 0; i < TMO; i++) begin
         applyStimulus(frz, 1'b1);
         checkValue("tmo_halt", 32'(halt), (i == TMO - 1) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(rdyOnly, 1'b1);
         checkValue("halt_sticky", 32'(lastDut), 32'(C_HALT));
      end
      applyStimulus(idle, 1'b0);
      checkValue("rst_halt_ctrl", 32'(lastDut), 32'(C_OFF));
      applyStimulus(idle, 1'b1);
      checkValue("rst_halt_cnt", 32'(stallCnt), 32'd0);
      checkValue("rst_halt_flag", 32'(halt), 32'd0);

      // Stall counter wraps from all-ones to zero
      applyStimulus(idle, 1'b0);
      for (int i = 0; i < (1 << DW) - 1; i++) applyStimulus(frz, 1'b1);
      checkValue("wrap_max", 32'(stallCnt), 32'((1 << DW) - 1));
      applyStimulus(frz, 1'b1);
      checkValue("wrap_zero", 32'(stallCnt), 32'd0);

      // Randomized traffic with occasional resets
      applyStimulus(idle, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         stim_t r;
         r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
                ($urandom_range(0, 9) < 7) ? 1 : 0);
         applyStimulus(r, ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
